// File: rtl/demux4_pkg.sv
`default_nettype none
// ============================================================================
// Module   : demux4_pkg
// Purpose  : Shared types and constants for the demux4_rr lane demultiplexer.
// Revision : 1.0
// ============================================================================
package demux4_pkg;

    localparam int LANES = 4;
    localparam int SEL_W = 2;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } demux_state_t;

    function automatic logic [LANES-1:0] sel_onehot(input logic [SEL_W-1:0] sel);
        logic [LANES-1:0] v;
        v = '0;
        v[sel] = 1'b1;
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/demux4_lane.sv
`default_nettype none
// ============================================================================
// Module   : demux4_lane
// Purpose  : Single held output lane: WIDTH-bit register with write enable.
// Revision : 1.0
// ============================================================================
module demux4_lane #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] r_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= '0;
        end else if (we) begin
            r_q <= d;
        end
    end

    assign q = r_q;

endmodule
`default_nettype wire

// File: rtl/demux4_rr.sv
`default_nettype none
// ============================================================================
// Module   : demux4_rr
// Purpose  : Registered 1-to-4 demux with explicit-select and round-robin
//            frame-assembly modes over a valid/ready input handshake.
// Revision : 1.0
// ============================================================================
module demux4_rr
    import demux4_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mode,
    input  logic [1:0]       s,
    input  logic [WIDTH-1:0] din,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] y0,
    output logic [WIDTH-1:0] y1,
    output logic [WIDTH-1:0] y2,
    output logic [WIDTH-1:0] y3,
    output logic [3:0]       y_upd,
    output logic             frame_valid,
    input  logic             frame_ack,
    output logic [1:0]       rr_ptr
);

    demux_state_t       r_state;
    logic               r_mode_q;
    logic [SEL_W-1:0]   r_rr_ptr;
    logic               r_frame_valid;
    logic [LANES-1:0]   r_y_upd;

    logic               w_mode_chg;
    logic               w_ready;
    logic               w_accept;
    logic [SEL_W-1:0]   w_sel;
    logic [LANES-1:0]   w_we;
    logic [WIDTH-1:0]   w_lane_q [LANES];

    // Ready depends only on state and the mode comparison, never on valid/data.
    assign w_mode_chg = (mode != r_mode_q);
    assign w_ready    = !w_mode_chg && (r_state == FILL);
    assign w_accept   = in_valid && w_ready;
    assign w_sel      = mode ? r_rr_ptr : s;
    assign w_we       = w_accept ? sel_onehot(w_sel) : '0;

    generate
        for (genvar k = 0; k < LANES; k++) begin : g_lane
            demux4_lane #(
                .WIDTH (WIDTH)
            ) u_lane (
                .clk   (clk),
                .rst_n (rst_n),
                .we    (w_we[k]),
                .d     (din),
                .q     (w_lane_q[k])
            );
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= FILL;
            r_mode_q      <= 1'b0;
            r_rr_ptr      <= '0;
            r_frame_valid <= 1'b0;
            r_y_upd       <= '0;
        end else begin
            r_mode_q <= mode;
            r_y_upd  <= w_we;
            if (w_mode_chg) begin
                // Switching modes abandons any partial frame; lanes keep contents.
                r_state       <= FILL;
                r_rr_ptr      <= '0;
                r_frame_valid <= 1'b0;
            end else if (mode) begin
                case (r_state)
                    FILL: begin
                        if (w_accept) begin
                            r_rr_ptr <= r_rr_ptr + 2'd1;
                            if (r_rr_ptr == 2'd3) begin
                                r_state       <= HOLD;
                                r_frame_valid <= 1'b1;
                            end
                        end
                    end
                    HOLD: begin
                        if (frame_ack && r_frame_valid) begin
                            r_state       <= FILL;
                            r_frame_valid <= 1'b0;
                        end
                    end
                    default: r_state <= FILL;
                endcase
            end else begin
                r_state <= FILL;
            end
        end
    end

    assign in_ready    = w_ready;
    assign y0          = w_lane_q[0];
    assign y1          = w_lane_q[1];
    assign y2          = w_lane_q[2];
    assign y3          = w_lane_q[3];
    assign y_upd       = r_y_upd;
    assign frame_valid = r_frame_valid;
    assign rr_ptr      = r_rr_ptr;

endmodule
`default_nettype wire
